// File: rtl/pc_seq_pkg.sv
// Shared constants and state encoding for the program-counter sequencer.
// Also used by the CPU top and benches so that reset/interrupt vectors agree.
package pc_seq_pkg;

    localparam int          PC_WIDTH     = 16;
    localparam logic [15:0] PC_RESET_VEC = 16'h0000;
    localparam logic [15:0] PC_IRQ_VEC   = 16'h0010;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_seq_if.sv
// Bundle between the sequencer, the loadable counter, the fetch port and the
// jump/halt/interrupt sources. The sequencer takes the master side.
// Optional macro PC_SEQ_IRQ_EN adds the irq/irq_ack pair.
interface pc_seq_if import pc_seq_pkg::*; #(
    parameter int WIDTH = PC_WIDTH
);
    // counter side
    logic [WIDTH-1:0] cnt_out;
    logic [WIDTH-1:0] cnt_data;
    logic             cnt_write;
    // fetch handshake
    logic             fetch_req;
    logic [WIDTH-1:0] fetch_addr;
    logic             fetch_ack;
    // jump handshake
    logic             jmp_valid;
    logic [WIDTH-1:0] jmp_target;
    logic             jmp_ready;
    // halt control
    logic             halt;
    logic             halted;
`ifdef PC_SEQ_IRQ_EN
    logic             irq;
    logic             irq_ack;
`endif

    modport master (
        input  cnt_out,
        output cnt_data, cnt_write,
        output fetch_req, fetch_addr,
        input  fetch_ack,
        input  jmp_valid, jmp_target,
        output jmp_ready,
        input  halt,
        output halted
`ifdef PC_SEQ_IRQ_EN
        , input  irq
        , output irq_ack
`endif
    );

    modport slave (
        output cnt_out,
        input  cnt_data, cnt_write,
        input  fetch_req, fetch_addr,
        output fetch_ack,
        output jmp_valid, jmp_target,
        input  jmp_ready,
        output halt,
        input  halted
`ifdef PC_SEQ_IRQ_EN
        , output irq
        , input  irq_ack
`endif
    );

endinterface

// File: rtl/pc_sequencer_irq_pending_latch.sv
// Interrupt pending flag: set by a request pulse, cleared when the
// sequencer acknowledges. A new request arriving in the acknowledge
// cycle wins so that it is not dropped.
module irq_pending_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic pending
);

    // Set-wins flag, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pending <= 1'b0;
        else if (set) pending <= 1'b1;
        else if (clr) pending <= 1'b0;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. Drives the loadable counter's data/write every
// cycle and paces instruction fetch through fetch_req/fetch_ack.
// Next counter value priority: boot vector > interrupt > jump > hold > increment.
// Optional macro PC_SEQ_IRQ_EN enables the interrupt path.
module pc_sequencer import pc_seq_pkg::*; #(
    parameter int               WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] IRQ_VEC   = WIDTH'(PC_IRQ_VEC)
) (
    input logic      clk,
    input logic      rst_n,
    pc_seq_if.master bus
);

    pc_state_e        state;
    logic             take_irq;
    logic [WIDTH-1:0] cnt_data_c;
    logic             cnt_write_c;
    logic             fetch_req_c;
    logic             jmp_ready_c;
    logic             irq_ack_c;
    logic             halted_c;

`ifdef PC_SEQ_IRQ_EN
    logic irq_pend;

    irq_pending_latch u_irq_pend (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (bus.irq),
        .clr     (irq_ack_c),
        .pending (irq_pend)
    );

    // An interrupt is taken on a fetch advance, or straight out of halt.
    assign take_irq = irq_pend &&
                      ((state == S_FETCH && bus.fetch_ack) || state == S_HALT);
    assign bus.irq_ack = irq_ack_c;
`else
    logic [WIDTH-1:0] irq_vec_unused;

    assign take_irq       = 1'b0;
    assign irq_vec_unused = IRQ_VEC;
`endif

    // Next-value select and handshake outputs; the counter itself is the
    // register stage, so these stay combinational. While in reset the state
    // is forced to S_BOOT, which yields the reset output values.
    always_comb begin
        cnt_write_c = 1'b1;
        cnt_data_c  = bus.cnt_out;
        fetch_req_c = 1'b0;
        jmp_ready_c = 1'b0;
        irq_ack_c   = 1'b0;
        halted_c    = 1'b0;
        case (state)
            S_BOOT: cnt_data_c = RESET_VEC;
            S_FETCH: begin
                fetch_req_c = 1'b1;
                // Without an ack the counter holds and any jump stays pending.
                if (bus.fetch_ack) begin
                    if (take_irq) begin
                        cnt_data_c = IRQ_VEC;
                        irq_ack_c  = 1'b1;
                    end else if (bus.jmp_valid) begin
                        cnt_data_c  = bus.jmp_target;
                        jmp_ready_c = 1'b1;
                    end else begin
                        cnt_write_c = 1'b0;
                    end
                end
            end
            S_HALT: begin
                halted_c = 1'b1;
                if (take_irq) begin
                    cnt_data_c = IRQ_VEC;
                    irq_ack_c  = 1'b1;
                end
            end
            default: cnt_data_c = RESET_VEC;
        endcase
    end

    assign bus.cnt_data   = cnt_data_c;
    assign bus.cnt_write  = cnt_write_c;
    assign bus.fetch_req  = fetch_req_c;
    assign bus.fetch_addr = bus.cnt_out;
    assign bus.jmp_ready  = jmp_ready_c;
    assign bus.halted     = halted_c;

    // Sequencer state: one boot cycle, then fetch; halt is entered only on an
    // advance so the in-flight fetch always completes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            case (state)
                S_BOOT:  state <= S_FETCH;
                S_FETCH: if (bus.fetch_ack && bus.halt) state <= S_HALT;
                S_HALT:  if (!bus.halt || take_irq)     state <= S_FETCH;
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer driving a behavioural 16-bit loadable counter.
// Stimulus pushes expected fetch transactions; a monitor pops and compares
// on every completed fetch (fetch_req && fetch_ack).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic        jr;
        logic        ia;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] cnt;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_seq_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Loadable counter: write=1 loads data, write=0 increments (wraps).
    always @(posedge clk) cnt <= bus.cnt_write ? bus.cnt_data : cnt + 16'd1;
    assign bus.cnt_out = cnt;

`ifdef PC_SEQ_IRQ_EN
    localparam logic [15:0] T7_BASE = 16'h0401;
`else
    localparam logic [15:0] T7_BASE = 16'h0301;
`endif

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare completed fetches against the scoreboard; outside an
    // advance no jump may be consumed.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (bus.fetch_req && bus.fetch_ack) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_fetch: got addr %h expected none", bus.fetch_addr);
                end else begin
                    e = sb.pop_front();
                    chk("fetch_addr", bus.fetch_addr, e.addr);
                    chk("jmp_ready", 16'(bus.jmp_ready), 16'(e.jr));
`ifdef PC_SEQ_IRQ_EN
                    chk("irq_ack", 16'(bus.irq_ack), 16'(e.ia));
`endif
                end
            end else begin
                chk("no_consume", 16'(bus.jmp_ready), 16'd0);
            end
        end
    end

    // One cycle of stimulus; optionally queue the fetch expected to complete.
    task automatic cyc(input logic ack, input logic jv, input logic [15:0] jt,
                       input logic hl, input logic ir, input bit push,
                       input logic [15:0] ea, input logic ejr, input logic eia);
        exp_t e;
        bus.fetch_ack  = ack;
        bus.jmp_valid  = jv;
        bus.jmp_target = jt;
        bus.halt       = hl;
`ifdef PC_SEQ_IRQ_EN
        bus.irq        = ir;
`else
        if (ir) $display("irq stimulus ignored in this build");
`endif
        if (push) begin
            e.addr = ea; e.jr = ejr; e.ia = eia;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fetch_req"}, 16'(bus.fetch_req), 16'd0);
        chk({tag, "_cnt_write"}, 16'(bus.cnt_write), 16'd1);
        chk({tag, "_cnt_data"},  bus.cnt_data,       16'h0000);
        chk({tag, "_jmp_ready"}, 16'(bus.jmp_ready), 16'd0);
        chk({tag, "_halted"},    16'(bus.halted),    16'd0);
`ifdef PC_SEQ_IRQ_EN
        chk({tag, "_irq_ack"},   16'(bus.irq_ack),   16'd0);
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        bus.fetch_ack = 1'b1;
        bus.jmp_valid = 1'b1;
        bus.jmp_target = 16'h1234;
        bus.halt = 1'b0;
`ifdef PC_SEQ_IRQ_EN
        bus.irq = 1'b0;
`endif
        // Reset: outputs at reset values, ack/jump ignored.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        chk("rst_cnt", bus.fetch_addr, 16'h0000);

        // Test 1: release, one boot cycle, then sequential fetches.
        rst_n = 1'b1;
        bus.jmp_valid = 1'b0;
        #1;
        chk("boot_fetch_req", 16'(bus.fetch_req), 16'd0);
        chk("boot_cnt_data", bus.cnt_data, 16'h0000);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1, 16'(i), 0, 0);

        // Test 2: three-cycle stall at 0005, counter holds.
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("stall_addr", bus.fetch_addr, 16'h0005);
            chk("stall_write", 16'(bus.cnt_write), 16'd1);
            chk("stall_data", bus.cnt_data, 16'h0005);
        end
        cyc(1, 0, 0, 0, 0, 1, 16'h0005, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 16'h0006, 0, 0);

        // Test 3: jump pending across a stall, consumed exactly once.
        cyc(0, 1, 16'h0100, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 16'h0100, 0, 0, 0, 0, 0, 0);
        chk("jstall_addr", bus.fetch_addr, 16'h0007);
        cyc(1, 1, 16'h0100, 0, 0, 1, 16'h0007, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 16'h0100, 0, 0);

        // Test 4: wrap FFFF -> 0000.
        cyc(1, 1, 16'hFFFF, 0, 0, 1, 16'h0101, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 16'hFFFF, 0, 0);
        chk("wrap_addr", bus.fetch_addr, 16'h0000);
        cyc(1, 0, 0, 0, 0, 1, 16'h0000, 0, 0);

        // Test 5: halt after fetch at 0020; jump ignored while halted.
        cyc(1, 1, 16'h0020, 0, 0, 1, 16'h0001, 1, 0);
        cyc(1, 0, 0, 1, 0, 1, 16'h0020, 0, 0);
        chk("halt_halted", 16'(bus.halted), 16'd1);
        chk("halt_fetch_req", 16'(bus.fetch_req), 16'd0);
        chk("halt_cnt_data", bus.cnt_data, 16'h0021);
        chk("halt_cnt_write", 16'(bus.cnt_write), 16'd1);
        cyc(1, 1, 16'h0300, 1, 0, 0, 0, 0, 0);
        chk("halt_hold", bus.fetch_addr, 16'h0021);
        chk("halt_jmp_ignored", 16'(bus.jmp_ready), 16'd0);
        cyc(0, 1, 16'h0300, 0, 0, 0, 0, 0, 0);
        chk("unhalt_halted", 16'(bus.halted), 16'd0);
        chk("unhalt_fetch_req", 16'(bus.fetch_req), 16'd1);
        chk("unhalt_addr", bus.fetch_addr, 16'h0021);
        cyc(1, 1, 16'h0300, 0, 0, 1, 16'h0021, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 16'h0300, 0, 0);

`ifdef PC_SEQ_IRQ_EN
        // Test 6: irq and jump on the same advance; irq wins, jump follows.
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 16'h0400, 0, 0, 1, 16'h0301, 0, 1);
        chk("irq_vec_addr", bus.fetch_addr, 16'h0010);
        cyc(1, 1, 16'h0400, 0, 0, 1, 16'h0010, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 16'h0400, 0, 0);
`endif

        // Test 7: reset asserted mid-stall at 0040.
        cyc(1, 1, 16'h0040, 0, 0, 1, T7_BASE, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_addr", bus.fetch_addr, 16'h0040);
        bus.fetch_ack = 1'b1;
        bus.jmp_valid = 1'b1;
        bus.jmp_target = 16'h0777;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.fetch_ack = 1'b0;
        bus.jmp_valid = 1'b0;
        n = 0;
        while (!bus.fetch_req && n < 3) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_latency_req", 16'(bus.fetch_req), 16'd1);
        chk("rst_latency_cycles_ok", 16'(n <= 2), 16'd1);
        chk("rst_first_addr", bus.fetch_addr, 16'h0000);
        cyc(1, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
